// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- control bundle between the ID-stage hazard sequencer and
// the rest of the pipeline. The pipeline side is the master: it drives the
// decode, load and data-memory status. The sequencer is the slave: it returns
// the enables, flushes and status. HAZARD_PERF_CNT_EN adds the stall/flush
// performance counters to the bundle.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
);
  logic [6:0]                IF_ID_inst_opcode;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic                      ID_EX_mem_rd_en;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
  logic                      EX_MEM_mem_rd_en;
  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd;
  logic                      branch_taken;
  logic                      dmem_req;
  logic                      dmem_ready;

  logic       pc_wr_en;
  logic       IF_ID_wr_en;
  logic       ID_EX_wr_en;
  logic       EX_MEM_wr_en;
  logic       IF_ID_flush;
  logic       ID_EX_flush;
  logic       MEM_WB_flush;
  logic [1:0] hazard_state;
  logic       mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] perf_ld_stall;
  logic [CNT_WIDTH-1:0] perf_br_stall;
  logic [CNT_WIDTH-1:0] perf_mem_stall;
  logic [CNT_WIDTH-1:0] perf_flush;

  modport master (
    output IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_rd_en, ID_EX_rd,
           EX_MEM_mem_rd_en, EX_MEM_rd, branch_taken, dmem_req, dmem_ready,
    input  pc_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en, IF_ID_flush,
           ID_EX_flush, MEM_WB_flush, hazard_state, mem_err,
           perf_ld_stall, perf_br_stall, perf_mem_stall, perf_flush
  );

  modport slave (
    input  IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_rd_en, ID_EX_rd,
           EX_MEM_mem_rd_en, EX_MEM_rd, branch_taken, dmem_req, dmem_ready,
    output pc_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en, IF_ID_flush,
           ID_EX_flush, MEM_WB_flush, hazard_state, mem_err,
           perf_ld_stall, perf_br_stall, perf_mem_stall, perf_flush
  );
`else
  modport master (
    output IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_rd_en, ID_EX_rd,
           EX_MEM_mem_rd_en, EX_MEM_rd, branch_taken, dmem_req, dmem_ready,
    input  pc_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en, IF_ID_flush,
           ID_EX_flush, MEM_WB_flush, hazard_state, mem_err
  );

  modport slave (
    input  IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_rd_en, ID_EX_rd,
           EX_MEM_mem_rd_en, EX_MEM_rd, branch_taken, dmem_req, dmem_ready,
    output pc_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en, IF_ID_flush,
           ID_EX_flush, MEM_WB_flush, hazard_state, mem_err
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall/flush sequencer for the 5-stage core. The controls are
// Mealy outputs decoded from the current inputs. The state register records
// which condition was active in the previous cycle and times data-memory waits.
// Define HAZARD_PERF_CNT_EN to add the stall/flush cycle counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | no stall last cycle
//   LD_STALL | load-use bubble inserted last cycle
//   BR_STALL | second bubble for a branch that depends on a load in MEM
//   MEM_WAIT | pipe frozen on data memory; wait timer running
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_WIDTH    = 32
`endif
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  // The wait timer counts down the cycles left in MEM_WAIT. It is reloaded
  // whenever the FSM is elsewhere, so it reads zero on the last allowed wait cycle.
  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mem_err;
  logic                uses_rs2, is_branch, mem_busy, ld_use, br_ld, timeout;

  function automatic logic reg_hit(input logic [REG_ADDR_WIDTH-1:0] rd,
                                   input logic [REG_ADDR_WIDTH-1:0] rs1,
                                   input logic [REG_ADDR_WIDTH-1:0] rs2,
                                   input logic                      use2);
    return (rd != '0) && ((rd == rs1) || (use2 && (rd == rs2)));
  endfunction

  // Decode the hazard conditions from the ID, EX and MEM stage fields.
  always_comb begin
    uses_rs2  = (bus.IF_ID_inst_opcode == OP_R) || (bus.IF_ID_inst_opcode == OP_S) ||
                (bus.IF_ID_inst_opcode == OP_B);
    is_branch = (bus.IF_ID_inst_opcode == OP_B);
    mem_busy  = bus.dmem_req && !bus.dmem_ready && !mem_err;
    ld_use    = bus.ID_EX_mem_rd_en &&
                reg_hit(bus.ID_EX_rd, bus.IF_ID_rs1, bus.IF_ID_rs2, uses_rs2);
    br_ld     = is_branch && bus.EX_MEM_mem_rd_en &&
                reg_hit(bus.EX_MEM_rd, bus.IF_ID_rs1, bus.IF_ID_rs2, uses_rs2);
    timeout   = (state == MEM_WAIT) && (wait_cnt == '0) && mem_busy;
  end

  // Priority resolve: freeze, then bubble, then branch flush.
  always_comb begin
    state_nxt        = RUN;
    bus.pc_wr_en     = 1'b1;
    bus.IF_ID_wr_en  = 1'b1;
    bus.ID_EX_wr_en  = 1'b1;
    bus.EX_MEM_wr_en = 1'b1;
    bus.IF_ID_flush  = 1'b0;
    bus.ID_EX_flush  = 1'b0;
    bus.MEM_WB_flush = 1'b0;
    if (mem_busy) begin
      state_nxt        = MEM_WAIT;
      bus.pc_wr_en     = 1'b0;
      bus.IF_ID_wr_en  = 1'b0;
      bus.ID_EX_wr_en  = 1'b0;
      bus.EX_MEM_wr_en = 1'b0;
      bus.MEM_WB_flush = 1'b1;
    end else if (ld_use || br_ld) begin
      state_nxt       = ld_use ? LD_STALL : BR_STALL;
      bus.pc_wr_en    = 1'b0;
      bus.IF_ID_wr_en = 1'b0;
      bus.ID_EX_flush = 1'b1;
    end else if (is_branch && bus.branch_taken) begin
      bus.IF_ID_flush = 1'b1;
    end
  end

  // State register, wait timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != MEM_WAIT)
        wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (timeout)
        mem_err <= 1'b1;
    end
  end

  assign bus.hazard_state = state;
  assign bus.mem_err      = mem_err;

`ifdef HAZARD_PERF_CNT_EN
  // Count the cycles in which each action wins the priority resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.perf_ld_stall  <= '0;
      bus.perf_br_stall  <= '0;
      bus.perf_mem_stall <= '0;
      bus.perf_flush     <= '0;
    end else begin
      if (mem_busy)
        bus.perf_mem_stall <= bus.perf_mem_stall + 1'b1;
      else if (ld_use)
        bus.perf_ld_stall <= bus.perf_ld_stall + 1'b1;
      else if (br_ld)
        bus.perf_br_stall <= bus.perf_br_stall + 1'b1;
      if (bus.IF_ID_flush)
        bus.perf_flush <= bus.perf_flush + 1'b1;
    end
  end
`endif

endmodule
